// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver. It deserialises 11-bit PS/2 frames, folds the 0xF0
// break prefix into a flag bit, and buffers key events in a small FIFO.
//
// Ports:
//   clk, rstn    system clock, synchronous active-low reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   nextdata_n   active-low pop request, honoured only while ready
//   data[8:0]    FIFO head {break, scan code}; zero while empty
//   ready        FIFO holds at least one event
//   overflow     sticky: an event was dropped because the FIFO was full
//   frame_err    one-cycle pulse on a bad start/stop/parity bit or a timeout
module ps2_event_rx #(
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [8:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0] PtrOne  = 1;

  logic ps2_clk_s1_q, ps2_clk_s1_d, ps2_clk_s2_q, ps2_clk_s2_d;
  logic ps2_clk_prev_q, ps2_clk_prev_d;
  logic ps2_data_s1_q, ps2_data_s1_d, ps2_data_s2_q, ps2_data_s2_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             frame_done_q, frame_done_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             overflow_q, overflow_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [8:0]       mem_q [Depth];

  logic       fall, tmo_hit, frame_ok, push, pop, full, wr_en;
  logic [7:0] scan_code;

  assign fall      = ps2_clk_prev_q & ~ps2_clk_s2_q;
  assign tmo_hit   = (bit_cnt_q != 4'd0) && !fall && (tmo_q == TmoLast);
  // shift_q holds bit 0 (start) in [0] and bit 10 (stop) in [10] once complete.
  assign scan_code = shift_q[8:1];
  assign frame_ok  = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign frame_err = (frame_done_q & ~frame_ok) | tmo_hit;

  assign ready    = (wptr_q != rptr_q);
  assign full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop      = ready & ~nextdata_n;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);
  assign data     = ready ? mem_q[rptr_q[FIFO_AW-1:0]] : 9'd0;
  assign overflow = overflow_q;

  always_comb begin
    ps2_clk_s1_d   = ps2_clk;
    ps2_clk_s2_d   = ps2_clk_s1_q;
    ps2_clk_prev_d = ps2_clk_s2_q;
    ps2_data_s1_d  = ps2_data;
    ps2_data_s2_d  = ps2_data_s1_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    tmo_d          = tmo_q;
    frame_done_d   = 1'b0;
    brk_d          = brk_q;
    ext_d          = ext_q;
    push           = 1'b0;

    if (fall) begin
      shift_d = {ps2_data_s2_q, shift_q[10:1]};
      tmo_d   = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d    = 4'd0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_hit) begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (frame_done_q && frame_ok) begin
      case (scan_code)
        8'hF0: brk_d = 1'b1;
        8'hE0: ext_d = 1'b1;
        // Keyboard status/ack bytes, not key events.
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
        default: begin
          push  = 1'b1;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end

    overflow_d = overflow_q | (push & full & ~pop);
    wptr_d     = wr_en ? wptr_q + PtrOne : wptr_q;
    rptr_d     = pop   ? rptr_q + PtrOne : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 11'd0;
      tmo_q          <= '0;
      frame_done_q   <= 1'b0;
      brk_q          <= 1'b0;
      ext_q          <= 1'b0;
      overflow_q     <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
    end else begin
      ps2_clk_s1_q   <= ps2_clk_s1_d;
      ps2_clk_s2_q   <= ps2_clk_s2_d;
      ps2_clk_prev_q <= ps2_clk_prev_d;
      ps2_data_s1_q  <= ps2_data_s1_d;
      ps2_data_s2_q  <= ps2_data_s2_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      tmo_q          <= tmo_d;
      frame_done_q   <= frame_done_d;
      brk_q          <= brk_d;
      ext_q          <= ext_d;
      overflow_q     <= overflow_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
    end
  end

  // Event storage needs no reset; data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= {brk_q, scan_code};
    end
  end

endmodule

// File: tb/tb_ps2_event_rx.sv
module tb_ps2_event_rx;

  localparam int unsigned Tmo = 2000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [8:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  ps2_event_rx #(
    .FIFO_AW       (3),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Cycles with frame_err high; a one-cycle pulse adds exactly one.
  always @(negedge clk) if (frame_err) err_cnt <= err_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of a frame for byte b; all drives happen on negedges.
  // chk_lat checks ready around the final falling edge, pop_push pops in the
  // cycle the event is written.
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                            input bit chk_lat, input bit pop_push);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && (chk_lat || pop_push)) begin
        repeat (3) @(negedge clk);
        if (chk_lat) check_eq("lat_not_yet", 32'(ready), 32'd0);
        if (pop_push) nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (chk_lat) check_eq("lat_ready", 32'(ready), 32'd1);
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'(ready), 32'd1);
    check_eq(tag, 32'(data), 32'(exp));
    pop_one();
  endtask

  logic [7:0] fill [8] = '{8'h15, 8'h16, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
  int e0, k;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Make/break of 'A'.
    send_frame(8'h1C, 11, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0);
    pop_expect("a_make", 9'h01C);
    pop_expect("a_break", 9'h11C);
    @(negedge clk);
    check_eq("a_empty", 32'(ready), 32'd0);

    // Bad parity then good frame.
    e0 = err_cnt;
    send_frame(8'h16, 11, 1'b1, 1'b0, 1'b0);
    check_eq("par_err", 32'(err_cnt - e0), 32'd1);
    check_eq("par_nopush", 32'(ready), 32'd0);
    send_frame(8'h16, 11, 1'b0, 1'b0, 1'b0);
    pop_expect("par_good", 9'h016);

    // Extended key release.
    send_frame(8'hE0, 11, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 11, 1'b0, 1'b0, 1'b0);
    pop_expect("ext", 9'h175);
    @(negedge clk);
    check_eq("ext_single", 32'(ready), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) send_frame(fill[i], 11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h2D, 11, 1'b0, 1'b0, 1'b1);
    check_eq("pp_noovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_expect("pp_order", {1'b0, fill[i]});
    pop_expect("pp_last", 9'h02D);
    @(negedge clk);
    check_eq("pp_empty", 32'(ready), 32'd0);

    // Overflow.
    for (int i = 0; i < 8; i++) send_frame(8'h16, 11, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_not_yet", 32'(overflow), 32'd0);
    send_frame(8'h16, 11, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_head", 32'(data), 32'h016);
    for (int i = 0; i < 8; i++) pop_expect("ovf_drain", 9'h016);
    @(negedge clk);
    check_eq("ovf_empty", 32'(ready), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Timeout after a partial frame.
    e0 = err_cnt;
    send_frame(8'h45, 5, 1'b0, 1'b0, 1'b0);
    k = 10;
    while (err_cnt == e0 && k < Tmo + 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("tmo_err", 32'(err_cnt - e0), 32'd1);
    check_eq("tmo_not_early", 32'(k >= Tmo - 10), 32'd1);
    send_frame(8'h45, 11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("tmo_next_rdy", 32'(ready), 32'd1);
    check_eq("tmo_next", 32'(data), 32'h045);

    // Reset mid-frame with an event still buffered.
    send_frame(8'h29, 5, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_ready", 32'(ready), 32'd0);
    check_eq("mid_data", 32'(data), 32'd0);
    check_eq("mid_ovf", 32'(overflow), 32'd0);
    check_eq("mid_err", 32'(frame_err), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    e0 = err_cnt;
    send_frame(8'h33, 11, 1'b0, 1'b0, 1'b0);
    check_eq("mid_noerr", 32'(err_cnt - e0), 32'd0);
    pop_expect("mid_next", 9'h033);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
